// File: rtl/gpio_pad_cfg_ctrl_pkg.sv
// Shared definitions for the GPIO pad configuration controller: pad-word
// field offsets, register addresses, reset word and sequencer states.
package gpio_cfg_pkg;

   localparam int unsigned DM_LSB      = 0;
   localparam int unsigned INP_DIS_BIT = 3;
   localparam int unsigned IB_MODE_BIT = 4;
   localparam int unsigned VTRIP_BIT   = 5;
   localparam int unsigned SLOW_BIT    = 6;
   localparam int unsigned OE_OFF_BIT  = 7;

   localparam logic [7:0] CTRL_ADDR   = 8'hF0;
   localparam logic [7:0] STATUS_ADDR = 8'hF4;

   localparam int unsigned CTRL_APPLY_BIT = 0;
   localparam int unsigned CTRL_LOCK_BIT  = 1;
   localparam int unsigned STAT_BUSY_BIT  = 0;
   localparam int unsigned STAT_ERR_BIT   = 1;
   localparam int unsigned STAT_LOCK_BIT  = 2;

   localparam logic [7:0] PAD_CFG_RST = 8'h81;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_SCAN,
      SEQ_ISOLATE,
      SEQ_SETTLE,
      SEQ_COMMIT,
      SEQ_NEXT,
      SEQ_DONE
   } seq_state_e;

endpackage

// File: rtl/gpio_pad_cfg_ctrl_if.sv
// Wishbone classic slave bundle for the GPIO pad configuration controller.
interface gpio_pad_cfg_ctrl_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [7:0]  wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o
   );
endinterface

// File: rtl/gpio_pad_cfg_ctrl_seq.sv
// Apply sequencer: walks every pad, isolating and settling each dirty one
// before the top commits its shadow word to the live registers.
module gpio_cfg_seq
   import gpio_cfg_pkg::*;
#(
   parameter int unsigned NUM_PADS      = 44,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                apply_i,
   input  logic [NUM_PADS-1:0] dirty_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                commit_o,
   output logic [5:0]          pad_idx_o,
   output logic [NUM_PADS-1:0] iso_o
);

   localparam logic [5:0] LAST_PAD    = 6'(NUM_PADS - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   seq_state_e state;
   logic [7:0] cnt;

   // busy stays high through the done pulse so it covers the whole sequence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEQ_IDLE;
         cnt       <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         pad_idx_o <= '0;
         iso_o     <= '0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               if (apply_i) begin
                  busy_o    <= 1'b1;
                  pad_idx_o <= '0;
                  state     <= SEQ_SCAN;
               end
            end
            SEQ_SCAN:
               state <= dirty_i[pad_idx_o] ? SEQ_ISOLATE : SEQ_NEXT;
            SEQ_ISOLATE: begin
               iso_o[pad_idx_o] <= 1'b1;
               cnt              <= SETTLE_LOAD;
               state            <= SEQ_SETTLE;
            end
            SEQ_SETTLE: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) state <= SEQ_COMMIT;
            end
            SEQ_COMMIT: begin
               iso_o[pad_idx_o] <= 1'b0;
               state            <= SEQ_NEXT;
            end
            SEQ_NEXT: begin
               if (pad_idx_o == LAST_PAD) begin
                  state <= SEQ_DONE;
               end else begin
                  pad_idx_o <= pad_idx_o + 6'd1;
                  state     <= SEQ_SCAN;
               end
            end
            SEQ_DONE: begin
               done_o <= 1'b1;
               state  <= SEQ_IDLE;
            end
            default: state <= SEQ_IDLE;
         endcase
      end
   end

   assign commit_o = (state == SEQ_COMMIT);

endmodule

// File: rtl/gpio_pad_cfg_ctrl.sv
// Wishbone-programmable GPIO pad configuration controller (shadow/live words).
// Optional write-once LOCK bit enabled by defining GPIO_CFG_LOCK_EN.
module gpio_pad_cfg_ctrl
   import gpio_cfg_pkg::*;
#(
   parameter int unsigned NUM_PADS      = 44,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rstn_i,
   gpio_pad_cfg_ctrl_if.slave  wb,
   input  logic [NUM_PADS-1:0] user_oeb_i,
   output logic [NUM_PADS-1:0] gpio_oeb,
   output logic [NUM_PADS-1:0] gpio_inp_dis,
   output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
   output logic [NUM_PADS-1:0] gpio_vtrip_sel,
   output logic [NUM_PADS-1:0] gpio_slow_sel,
   output logic [NUM_PADS-1:0] gpio_dm2,
   output logic [NUM_PADS-1:0] gpio_dm1,
   output logic [NUM_PADS-1:0] gpio_dm0,
   output logic                busy_o,
   output logic                done_irq_o
);

   logic [7:0]          shadow [NUM_PADS];
   logic [7:0]          live   [NUM_PADS];
   logic [NUM_PADS-1:0] dirty;
   logic [NUM_PADS-1:0] iso;
   logic [5:0]          pad_idx;
   logic                commit;
   logic                apply;
   logic                err;
   logic                lock;
   logic                blocked;
   logic                req, wr_en;
   logic [5:0]          word_idx;
   logic                pad_hit, ctrl_hit, stat_hit;
   logic [31:0]         rdata;
   logic                unused_ok;

   assign req      = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
   assign wr_en    = req & wb.wbs_we_i & wb.wbs_sel_i[0];
   assign word_idx = wb.wbs_adr_i[7:2];
   assign pad_hit  = (word_idx < 6'(NUM_PADS));
   assign ctrl_hit = (word_idx == CTRL_ADDR[7:2]);
   assign stat_hit = (word_idx == STATUS_ADDR[7:2]);
   assign blocked  = busy_o | lock;

   assign unused_ok = &{1'b0, wb.wbs_sel_i[3:1], wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:8]};

`ifdef GPIO_CFG_LOCK_EN
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i)
         lock <= 1'b0;
      else if (wr_en && ctrl_hit && wb.wbs_dat_i[CTRL_LOCK_BIT])
         lock <= 1'b1;
   end
`else
   assign lock = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
         err          <= 1'b0;
         apply        <= 1'b0;
      end else begin
         wb.wbs_ack_o <= req;
         wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rdata : '0;
         apply        <= 1'b0;
         if (wr_en) begin
            if (pad_hit && blocked) err <= 1'b1;
            if (ctrl_hit && wb.wbs_dat_i[CTRL_APPLY_BIT]) begin
               if (blocked) err   <= 1'b1;
               else         apply <= 1'b1;
            end
            if (stat_hit && wb.wbs_dat_i[STAT_ERR_BIT]) err <= 1'b0;
         end
      end
   end

   // Shadow is bus-owned, live is sequencer-owned; shadow is frozen while busy.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         for (int unsigned i = 0; i < NUM_PADS; i++) begin
            shadow[i] <= PAD_CFG_RST;
            live[i]   <= PAD_CFG_RST;
         end
      end else begin
         if (wr_en && pad_hit && !blocked) shadow[word_idx] <= wb.wbs_dat_i[7:0];
         if (commit) live[pad_idx] <= shadow[pad_idx];
      end
   end

   always_comb begin
      rdata = '0;
      if (pad_hit) begin
         rdata[7:0] = shadow[word_idx];
      end else if (ctrl_hit) begin
         rdata[CTRL_LOCK_BIT] = lock;
      end else if (stat_hit) begin
         rdata[STAT_BUSY_BIT] = busy_o;
         rdata[STAT_ERR_BIT]  = err;
         rdata[STAT_LOCK_BIT] = lock;
         rdata[13:8]          = pad_idx;
      end
   end

   always_comb begin
      dirty            = '0;
      gpio_oeb         = '0;
      gpio_inp_dis     = '0;
      gpio_ib_mode_sel = '0;
      gpio_vtrip_sel   = '0;
      gpio_slow_sel    = '0;
      gpio_dm2         = '0;
      gpio_dm1         = '0;
      gpio_dm0         = '0;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
         dirty[i]            = (shadow[i] != live[i]);
         gpio_oeb[i]         = live[i][OE_OFF_BIT] | user_oeb_i[i] | iso[i];
         gpio_inp_dis[i]     = live[i][INP_DIS_BIT];
         gpio_ib_mode_sel[i] = live[i][IB_MODE_BIT];
         gpio_vtrip_sel[i]   = live[i][VTRIP_BIT];
         gpio_slow_sel[i]    = live[i][SLOW_BIT];
         gpio_dm2[i]         = live[i][DM_LSB+2];
         gpio_dm1[i]         = live[i][DM_LSB+1];
         gpio_dm0[i]         = live[i][DM_LSB];
      end
   end

   gpio_cfg_seq #(
      .NUM_PADS      (NUM_PADS),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_seq (
      .clk       (wb_clk_i),
      .rst_n     (wb_rstn_i),
      .apply_i   (apply),
      .dirty_i   (dirty),
      .busy_o    (busy_o),
      .done_o    (done_irq_o),
      .commit_o  (commit),
      .pad_idx_o (pad_idx),
      .iso_o     (iso)
   );

endmodule

// File: doc/gpio_pad_cfg_ctrl.md
# gpio_pad_cfg_ctrl

Wishbone-programmable configuration controller for the OpenFrame GPIO pads. Holds a shadow configuration word per pad, and on software command commits changed words to the live pad-control outputs (`gpio_dm*`, `gpio_inp_dis`, `gpio_ib_mode_sel`, `gpio_vtrip_sel`, `gpio_slow_sel`). Each changed pad is first isolated with its output driver disabled, held for a settle interval, then updated. The block sits inside `openframe_project_wrapper` between the SoC bus and the pad ring. Analog, holdover and polarity pins stay tied to loopback-zero outside this block.

## Interface
Parameters:
- `NUM_PADS`, 44: number of pads controlled; must be ≤ 60.
- `SETTLE_CYCLES`, 4: isolation hold per pad, in clocks; range 1..255.

Ports:
- `wb_clk_i`  in  1  system clock.
- `wb_rstn_i`  in  1  asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic slave controls.
- `wbs_sel_i`  in  4  byte lanes; only lane 0 is used for writes.
- `wbs_adr_i`  in  8  byte address, word aligned.
- `wbs_dat_i`  in  32  write data.
- `wbs_dat_o`  out  32  read data.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `user_oeb_i`  in  NUM_PADS  core-requested output-enable-bar, one per pad.
- `gpio_oeb`  out  NUM_PADS  pad output-enable-bar.
- `gpio_inp_dis`, `gpio_ib_mode_sel`, `gpio_vtrip_sel`, `gpio_slow_sel`  out  NUM_PADS each  live pad configuration.
- `gpio_dm2`, `gpio_dm1`, `gpio_dm0`  out  NUM_PADS each  live drive mode.
- `busy_o`  out  1  apply sequence in progress.
- `done_irq_o`  out  1  one-cycle pulse when an apply sequence completes.

## Operation
Pad word layout, bits [7:0]:
- [2:0] dm
- [3] inp_dis
- [4] ib_mode_sel
- [5] vtrip_sel
- [6] slow_sel
- [7] oe_force_off

Bits [31:8] read 0.

Register map:
- `0x00 + 4*i`, i < NUM_PADS: shadow word for pad i. A read returns the shadow word.
- `0xF0` CTRL: write bit0 = 1 → APPLY (self-clearing). Bit1 = LOCK (macro only).
- `0xF4` STATUS, read-only: bit0 busy, bit1 err (sticky), bits [13:8] current pad index. Writing 1 to bit1 clears err.
- Unmapped addresses: acked, read 0, writes ignored.

Live state and outputs:
- Dirty pad: shadow word ≠ live word.
- `gpio_oeb[i] = live.oe_force_off[i] | user_oeb_i[i] | iso[i]`.
- The dm, inp_dis, ib_mode_sel, vtrip_sel and slow_sel outputs come directly from live registers.

Sequencer FSM:
- IDLE: APPLY → SCAN with p = 0, busy set.
- SCAN: pad p clean → NEXT; dirty → ISOLATE.
- ISOLATE: set iso[p], load counter with SETTLE_CYCLES → SETTLE.
- SETTLE: decrement counter; at 0 → COMMIT.
- COMMIT: live[p] ← shadow[p], clear iso[p] → NEXT.
- NEXT: if p = NUM_PADS−1 → DONE, else p++ → SCAN.
- DONE: pulse `done_irq_o`, clear busy → IDLE.

Boundary rules:
- Shadow write while busy: acked, data ignored, err set.
- APPLY while busy: ignored, err set.
- APPLY with no dirty pads: full scan still runs and `done_irq_o` still pulses.
- Reset mid-sequence: all state returns to reset values immediately and iso clears.
- A read and the FSM never conflict; live registers are FSM-owned only.

## Timing
- `wbs_ack_o` asserts the cycle after `cyc & stb`, for one cycle. The next request is accepted no earlier than the cycle after ack (no back-to-back ack).
- A write takes effect on the ack edge. APPLY sets `busy_o` on the cycle after ack.
- Sequence length = 2 + NUM_PADS·2 + D·(SETTLE_CYCLES+2) cycles, where D = number of dirty pads. Each clean pad costs SCAN+NEXT.
- iso[p] is high for exactly SETTLE_CYCLES+1 cycles, before the live value changes.
- Reset values:
  - live and shadow dm = 3'b001, oe_force_off = 1, all other bits 0.
  - `gpio_oeb` all 1; `busy_o` = 0, `done_irq_o` = 0, `wbs_ack_o` = 0, `wbs_dat_o` = 0; err = 0; p = 0.

## Configuration
- `GPIO_CFG_LOCK_EN` defined: CTRL bit1 LOCK is write-once-set. While LOCK = 1:
  - shadow writes and APPLY are acked but ignored, and set err;
  - LOCK clears only on reset;
  - STATUS bit2 reads LOCK.
- `GPIO_CFG_LOCK_EN` undefined: CTRL bit1 and STATUS bit2 read 0 and writes to them have no effect.

## Structure
- Package `gpio_cfg_pkg` holds:
  - the pad-word field offsets;
  - register address constants (`CTRL_ADDR`, `STATUS_ADDR`);
  - the FSM state enum;
  - reset pad-word constant `PAD_CFG_RST` = 8'h81.
- Natural sub-module: `gpio_cfg_seq`, containing the FSM, pad index, settle counter and iso vector. The Wishbone decode and register arrays stay in the top.

## Test plan
- Reset released → all `gpio_oeb` = 1, dm = 001 on every pad, `busy_o` = 0, STATUS reads 0x0.
- Write pad 5 = 0x06, APPLY → `gpio_oeb[5]` high for 5 cycles, then dm[5] = 110 and `gpio_oeb[5]` follows `user_oeb_i[5]`. Total busy = 96 cycles, then a 1-cycle `done_irq_o`.
- APPLY with no changes → busy = 90 cycles, no iso asserted, `done_irq_o` pulses.
- Write pad 3 while busy → ack, shadow[3] unchanged, STATUS err = 1. Writing 0x2 to STATUS clears err.
- `wb_rstn_i` pulsed low during SETTLE of pad 40 → iso clears, live pad 40 = 0x81, `busy_o` = 0 asynchronously.
- With `GPIO_CFG_LOCK_EN`: set LOCK, write pad 0, APPLY → no busy, err = 1, shadow[0] unchanged.
